dcache_responder: RTL

//  Responder end of the core's data-memory port: serves load/store requests issued by the MEM stage,

---
 rtl/dcache_responder_pkg.sv | 23 ++
 rtl/dcache_responder_line_array.sv | 57 +++++
 rtl/dcache_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the data-cache responder: geometry defaults, FSM encodings, byte merge.
package dcache_responder_pkg;

   localparam int ADDR_W         = 30;
   localparam int LINE_WORDS_DEF = 4;
   localparam int NUM_LINES_DEF  = 64;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REFILL = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_responder_line_array.sv
// dcache_line_array: valid/tag/data storage for the direct-mapped cache, combinational read,
// one byte-strobed data write port plus line invalidate and line fill (tag + valid) updates.
module dcache_line_array
   import dcache_responder_pkg::*;
#(
   parameter int  LINE_WORDS = LINE_WORDS_DEF,
   parameter int  NUM_LINES  = NUM_LINES_DEF,
   localparam int OFF_W      = $clog2(LINE_WORDS),
   localparam int IDX_W      = $clog2(NUM_LINES),
   localparam int TAG_W      = ADDR_W - OFF_W - IDX_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic [OFF_W-1:0] rd_offset_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic [31:0]      rd_data_o,
   input  logic             wr_en_i,
   input  logic [OFF_W-1:0] wr_offset_i,
   input  logic [3:0]       wr_strb_i,
   input  logic [31:0]      wr_data_i,
   input  logic             inval_i,
   input  logic             fill_i,
   input  logic [TAG_W-1:0] fill_tag_i
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_mem_q  [NUM_LINES];
   logic [31:0]          data_mem_q [NUM_LINES*LINE_WORDS];

   logic [IDX_W+OFF_W-1:0] rd_addr, wr_addr;

   assign rd_addr    = {index_i, rd_offset_i};
   assign wr_addr    = {index_i, wr_offset_i};
   assign rd_valid_o = valid_q[index_i];
   assign rd_tag_o   = tag_mem_q[index_i];
   assign rd_data_o  = data_mem_q[rd_addr];

   always_comb begin
      valid_d = valid_q;
      if (inval_i) valid_d[index_i] = 1'b0;
      if (fill_i)  valid_d[index_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // Tag and data storage carry no reset; only the valid bits make them meaningful.
   always_ff @(posedge clk_i) begin
      if (fill_i)  tag_mem_q[index_i]  <= fill_tag_i;
      if (wr_en_i) data_mem_q[wr_addr] <= merge_bytes(data_mem_q[wr_addr], wr_data_i, wr_strb_i);
   end

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, read-allocate, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add the stat_hit_o / stat_miss_o counters.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int NUM_LINES  = NUM_LINES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic [29:0] core_addr_i,
   input  logic [3:0]  core_write_en_i,
   input  logic [31:0] core_data_i,
   output logic [31:0] core_data_o,
   output logic        core_busy_o,
`ifdef DCACHE_STATS_EN
   output logic [31:0] stat_hit_o,
   output logic [31:0] stat_miss_o,
`endif
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [29:0] mem_addr_o,
   output logic [3:0]  mem_wstrb_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_index;
   logic [OFF_W-1:0] req_offset;
   logic             is_load, is_store, hit;

   logic             line_valid;
   logic [TAG_W-1:0] line_tag;
   logic [31:0]      line_data;

   logic             arr_wr_en, arr_inval, arr_fill;
   logic [OFF_W-1:0] arr_wr_offset;
   logic [3:0]       arr_wr_strb;
   logic [31:0]      arr_wr_data;

   logic [1:0]       state_q, state_d;
   logic [OFF_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [OFF_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             issue_done_q, issue_done_d;

   assign req_tag    = core_addr_i[ADDR_W-1 -: TAG_W];
   assign req_index  = core_addr_i[OFF_W +: IDX_W];
   assign req_offset = core_addr_i[OFF_W-1:0];
   assign is_load    = core_req_i && (core_write_en_i == 4'b0000);
   assign is_store   = core_req_i && (core_write_en_i != 4'b0000);
   assign hit        = line_valid && (line_tag == req_tag);

   assign mem_wstrb_o = core_write_en_i;
   assign mem_wdata_o = core_data_i;

   dcache_line_array #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES)
   ) u_lines (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .index_i     (req_index),
      .rd_offset_i (req_offset),
      .rd_valid_o  (line_valid),
      .rd_tag_o    (line_tag),
      .rd_data_o   (line_data),
      .wr_en_i     (arr_wr_en),
      .wr_offset_i (arr_wr_offset),
      .wr_strb_i   (arr_wr_strb),
      .wr_data_i   (arr_wr_data),
      .inval_i     (arr_inval),
      .fill_i      (arr_fill),
      .fill_tag_i  (req_tag)
   );

   always_comb begin
      state_d       = state_q;
      issue_cnt_d   = issue_cnt_q;
      beat_cnt_d    = beat_cnt_q;
      issue_done_d  = issue_done_q;
      core_busy_o   = 1'b0;
      core_data_o   = '0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = core_addr_i;
      arr_wr_en     = 1'b0;
      arr_inval     = 1'b0;
      arr_fill      = 1'b0;
      arr_wr_offset = req_offset;
      arr_wr_strb   = core_write_en_i;
      arr_wr_data   = core_data_i;

      case (state_q)
         ST_IDLE: begin
            if (is_load) begin
               if (hit) begin
                  core_data_o = line_data;
               end else begin
                  core_busy_o  = 1'b1;
                  arr_inval    = 1'b1;
                  issue_cnt_d  = '0;
                  beat_cnt_d   = '0;
                  issue_done_d = 1'b0;
                  state_d      = ST_REFILL;
               end
            end else if (is_store) begin
               core_busy_o = 1'b1;
               state_d     = ST_WRITE;
            end
         end
         ST_REFILL: begin
            // Read issue and beat capture run independently; the line is marked valid only
            // when the final beat lands.
            core_busy_o = 1'b1;
            mem_req_o   = !issue_done_q;
            mem_addr_o  = {req_tag, req_index, issue_cnt_q};
            if (mem_req_o && mem_ready_i) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == LAST_WORD) issue_done_d = 1'b1;
            end
            if (mem_rvalid_i) begin
               arr_wr_en     = 1'b1;
               arr_wr_offset = beat_cnt_q;
               arr_wr_strb   = 4'hF;
               arr_wr_data   = mem_rdata_i;
               beat_cnt_d    = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_WORD) begin
                  arr_fill = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_WRITE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            core_busy_o = !mem_ready_i;
            if (mem_ready_i) begin
               arr_wr_en = hit;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst_i) begin
         core_busy_o = 1'b0;
         core_data_o = '0;
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         arr_wr_en   = 1'b0;
         arr_inval   = 1'b0;
         arr_fill    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         issue_cnt_q  <= '0;
         beat_cnt_q   <= '0;
         issue_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         issue_done_q <= issue_done_d;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hit_q, stat_hit_d;
   logic [31:0] stat_miss_q, stat_miss_d;
   logic        refilled_q, refilled_d;

   // The load that completes right after a refill was already counted as a miss.
   always_comb begin
      stat_hit_d  = stat_hit_q;
      stat_miss_d = stat_miss_q;
      refilled_d  = arr_fill;
      if (state_q == ST_IDLE && is_load) begin
         if (!hit)            stat_miss_d = stat_miss_q + 32'd1;
         else if (!refilled_q) stat_hit_d = stat_hit_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_hit_q  <= '0;
         stat_miss_q <= '0;
         refilled_q  <= 1'b0;
      end else begin
         stat_hit_q  <= stat_hit_d;
         stat_miss_q <= stat_miss_d;
         refilled_q  <= refilled_d;
      end
   end

   assign stat_hit_o  = stat_hit_q;
   assign stat_miss_o = stat_miss_q;
`endif

endmodule
